// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sample driver.
// Holds default sizes, LFSR polynomial, FSM states and var layout.
package constraint_sampler_pkg;

    localparam int DEF_VEC_W     = 368;
    localparam int DEF_N_CONS    = 35;
    localparam int DEF_MAX_TRIES = 1024;
    localparam int LFSR_W        = 64;

    // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois taps
    localparam logic [LFSR_W-1:0] LFSR_POLY  = 64'hD800_0000_0000_0000;
    localparam logic [LFSR_W-1:0] LFSR_RESET = 64'h1;

    // Layout of var_k inside cand_o; var_0 sits in the LSBs
    localparam int N_VARS = 7;
    localparam int VAR_W   [N_VARS] = '{64, 64, 64, 64, 64, 32, 16};
    localparam int VAR_OFF [N_VARS] = '{0, 64, 128, 192, 256, 320, 352};

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        OUT
    } state_t;

    // Advance the Galois LFSR by LFSR_W single-bit steps
    function automatic logic [LFSR_W-1:0] lfsr_adv(
        input logic [LFSR_W-1:0] s
    );
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < LFSR_W; i++) begin
            r = r[0] ? ((r >> 1) ^ LFSR_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cons_priority_enc.sv
// Lowest-index zero finder over the constraint result bits.
// Returns 0 when no bit is zero; the caller only uses it on failures.
module cons_priority_enc #(
    parameter int N = 35,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] cons,
    output logic [W-1:0] idx
);

    // Scan from the top so the lowest zero wins
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!cons[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/constraint_sample_driver.sv
// Constraint sample driver: fills candidates from an LFSR, checks them
// against the constraint bits and retries until accepted or exhausted.
module constraint_sample_driver
    import constraint_sampler_pkg::*;
#(
    parameter int VEC_W     = DEF_VEC_W,
    parameter int N_CONS    = DEF_N_CONS,
    parameter int MAX_TRIES = DEF_MAX_TRIES,
    parameter int IDX_W     = $clog2(N_CONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [VEC_W-1:0]  cand_o,
    input  logic [N_CONS-1:0] cons_i,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              busy_o,
    output logic              fail_o,
    output logic [15:0]       tries_o,
    output logic [IDX_W-1:0]  viol_idx_o
);

    localparam int FILL_CYCLES = (VEC_W + LFSR_W - 1) / LFSR_W;
    localparam int FC_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILL_CYCLES - 1);
    localparam logic [15:0] MAX_T = 16'(MAX_TRIES);

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] chunk;
    logic [FC_W-1:0]   fill_cnt;
    logic [15:0]       tries_nxt;
    logic [IDX_W-1:0]  viol_idx;

    assign chunk     = lfsr_adv(lfsr);
    assign tries_nxt = tries_o + 16'd1;

    cons_priority_enc #(
        .N (N_CONS),
        .W (IDX_W)
    ) u_penc (
        .cons (cons_i),
        .idx  (viol_idx)
    );

    // Request FSM: fill, check, retry or present, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= LFSR_RESET;
            cand_o         <= '0;
            fill_cnt       <= '0;
            tries_o        <= '0;
            viol_idx_o     <= '0;
            sample_valid_o <= 1'b0;
            fail_o         <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            fail_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (seed_load_i) begin
                        lfsr <= (seed_i == '0) ? LFSR_RESET : seed_i;
                    end
                    if (start_i) begin
                        state    <= FILL;
                        busy_o   <= 1'b1;
                        tries_o  <= '0;
                        fill_cnt <= '0;
                    end
                end
                FILL: begin
                    lfsr   <= chunk;
                    cand_o <= {cand_o[VEC_W-LFSR_W-1:0], chunk};
                    if (fill_cnt == FC_LAST) begin
                        fill_cnt <= '0;
                        state    <= CHECK;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    tries_o <= tries_nxt;
                    if (&cons_i) begin
                        state          <= OUT;
                        sample_valid_o <= 1'b1;
                    end else begin
                        viol_idx_o <= viol_idx;
                        if (tries_nxt == MAX_T) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            fail_o <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                OUT: begin
                    if (sample_ready_i) begin
                        state          <= IDLE;
                        sample_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/constraint_sample_driver.md
Name: constraint_sample_driver

Overview:
- Candidate generator and acceptance controller that sits directly upstream of a generated combinational constraint module (inputs var_0..var_N, outputs constraint_0..constraint_M).
- Fills a flat candidate vector from an LFSR, drives it into the constraint module, and reads back the constraint bits in the same cycle.
- If every bit is 1, presents the candidate as an accepted sample over a valid/ready handshake; otherwise it retries until MAX_TRIES, then reports failure.

Parameters:
- VEC_W, 368, width of the concatenated candidate (sum of all var widths; var_0 occupies the LSBs).
- N_CONS, 35, number of constraint bits returned.
- MAX_TRIES, 1024, evaluations per request before giving up (1..65535).
- LFSR_W, 64, LFSR state width and chunk width per fill cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; synchronous, active-high
- start_i  in  1  request one sample; honoured in IDLE only
- seed_load_i  in  1  load seed_i into the LFSR; honoured in IDLE only
- seed_i  in  LFSR_W  seed value
- cand_o  out  VEC_W  candidate driven to the constraint module
- cons_i  in  N_CONS  constraint results for cand_o, combinational, same cycle
- sample_valid_o  out  1  accepted sample available
- sample_ready_i  in  1  consumer accepts the sample
- busy_o  out  1  high whenever state != IDLE
- fail_o  out  1  one-cycle pulse when MAX_TRIES is exhausted
- tries_o  out  16  evaluations used for the current or last request
- viol_idx_o  out  $clog2(N_CONS)  lowest-index 0 bit of the last failed check

Behaviour:
- Reset (synchronous): state=IDLE, LFSR=64'h1, cand_o=0, tries_o=0, viol_idx_o=0, sample_valid_o=0, fail_o=0, busy_o=0. Reset overrides everything, including mid-FILL or mid-OUT; any in-flight sample is dropped without a pulse.
- LFSR: Galois, polynomial x^64+x^63+x^61+x^60+1. It advances exactly 64 single-bit steps per fill cycle (unrolled). The chunk value is the post-advance state.
- Seed: on seed_load_i in IDLE, LFSR <= seed_i, except seed_i==0 loads 64'h1. If seed_load_i and start_i are both high, the seed loads first and start is accepted on the same edge; the fill uses the new seed.
- Fill: FILL_CYCLES = ceil(VEC_W/LFSR_W) = 6. Each FILL edge does cand <= {cand, chunk} truncated to VEC_W. The first chunk ends up highest; the upper 16 bits of the first chunk are discarded.
- States:
  - IDLE: start_i -> FILL; tries_o<=0, fill counter<=0.
  - FILL: load one chunk per edge. After the 6th load -> CHECK.
  - CHECK: cand_o stable for the whole cycle; tries_o<=tries_o+1.
    - &cons_i==1 -> OUT.
    - Else record viol_idx_o. If tries_o+1==MAX_TRIES -> IDLE with fail_o=1 for one cycle. Else -> FILL.
  - OUT: sample_valid_o=1 and cand_o held constant. On sample_valid_o&&sample_ready_i -> IDLE.
- Handshake: sample_valid_o never drops without a handshake. cand_o must not change while valid. sample_ready_i is ignored outside OUT.
- Latency: start edge E0 to sample_valid_o high after edge E7 on first-try success. Each retry adds 7 cycles. Failure pulse follows MAX_TRIES*7 edges after E0.
- cand_o changes only during FILL edges. start_i while busy is ignored, with no queuing.
- tries_o holds its final value in IDLE until the next start.
- viol_idx_o updates only on failed checks.

Decomposition:
- Package constraint_sampler_pkg holds:
  - VEC_W, N_CONS and LFSR_W defaults;
  - LFSR polynomial constant;
  - state enum (IDLE, FILL, CHECK, OUT);
  - per-var offset/width constants for slicing cand_o into var_k at the integration top.
- One sub-module: cons_priority_enc, a combinational lowest-zero finder, N_CONS -> $clog2(N_CONS).

Test Plan:
- Stub cons_i=all ones, seed 64'h1, start pulse -> sample_valid_o high 7 cycles after the start edge; tries_o=1; cand_o matches a golden LFSR model.
- cons_i bit 5 tied 0, MAX_TRIES=4 -> four CHECK cycles 7 apart; fail_o single pulse at edge 28; tries_o=4; viol_idx_o=5; busy_o=0 afterwards.
- cons_i = all ones from the 3rd CHECK onward -> accept on tries_o=3; sample_valid_o rises at edge 21.
- Pass then hold sample_ready_i=0 for 10 cycles -> sample_valid_o and cand_o constant; ready=1 -> return to IDLE the next cycle; start during OUT ignored.
- seed_load_i with seed_i=0 -> fill identical to seed 64'h1. seed_load_i=1 while busy -> ignored.
- Assert rst in the 3rd FILL cycle -> next cycle all outputs at reset values; a new start reproduces the seed-1 sample exactly.
